// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the Wishbone configuration loader: register map,
// STATUS/CTRL bit positions and the serializer state encoding.
package cfg_loader_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_CTRL   = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_BITCNT = 4'hC;

  localparam int unsigned CTRL_CLEAR_BIT = 0;

  localparam int unsigned ST_DONE_BIT  = 0;
  localparam int unsigned ST_BUSY_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_LEVEL_LSB = 4;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } ldr_state_e;

  // Assemble the STATUS register image from its individual fields.
  function automatic logic [31:0] pack_status(input logic       done,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic [3:0] level);
    logic [31:0] s;
    s                      = '0;
    s[ST_DONE_BIT]         = done;
    s[ST_BUSY_BIT]         = busy;
    s[ST_OVF_BIT]          = ovf;
    s[ST_LEVEL_LSB +: 4]   = level;
    return s;
  endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous word FIFO with flush. Pointers carry one extra wrap bit so
// full/empty/level come straight from the pointer difference.
module cfg_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level    = wptr_q - rptr_q;
  assign pop_data = mem_q[rptr_q[AW-1:0]];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointer advance; flush discards all stored words.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_cfg_loader.sv
// Wishbone slave that buffers 32-bit config words and shifts them LSB-first
// into one column's configuration chain, raising set_out once the column
// has received exactly BITS_PER_COL bits.
module wb_cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned BITS_PER_COL = 1024,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        shift_out,
  output logic        cen,
  output logic        set_out
);

  localparam int unsigned CNT_W = $clog2(BITS_PER_COL + 1);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  ldr_state_e        state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [5:0]        wbits_q, wbits_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              cen_q, cen_d;
  logic              shift_q, shift_d;
  logic              set_q, set_d;
  logic              ovf_q, ovf_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;

  logic              fifo_pop, fifo_push, fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_rd;
  logic [LVL_W-1:0]  fifo_level;

  logic              in_window, req, data_wr, push_req, accept, clear, ovf_hit, busy;
  logic [3:0]        offs;
  logic [31:0]       rd_data;

  assign offs      = wbs_adr_i[3:0];
  assign in_window = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // ack_q masks the request so a strobe held through the ack cycle is not re-acked.
  assign req       = wbs_stb_i && wbs_cyc_i && in_window && !ack_q;
  assign data_wr   = wbs_we_i && (offs == REG_DATA) && (wbs_sel_i == 4'hF);
  assign push_req  = data_wr && (state_q != DONE);
  // A push into a full FIFO is held off (no ack) until a slot frees.
  assign accept    = req && !(push_req && fifo_full);
  assign fifo_push = accept && push_req;
  assign ovf_hit   = accept && data_wr && (state_q == DONE);
  assign clear     = accept && wbs_we_i && (offs == REG_CTRL) && wbs_dat_i[CTRL_CLEAR_BIT];
  assign busy      = (state_q == SHIFT) || !fifo_empty;

  cfg_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .flush     (clear),
    .push      (fifo_push),
    .push_data (wbs_dat_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    rd_data = '0;
    case (offs)
      REG_STATUS: rd_data = pack_status(set_q, busy, ovf_q, 4'(fifo_level));
      REG_BITCNT: rd_data = 32'(bitcnt_q);
      default:    rd_data = '0;
    endcase
  end

  // Bus response: one-cycle ack per accepted access, read data captured with it.
  always_comb begin
    ack_d = accept;
    dat_d = (accept && !wbs_we_i) ? rd_data : '0;
  end

  // Serializer next state: pop, shift, terminal count and clear.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    wbits_d  = wbits_q;
    bitcnt_d = bitcnt_q;
    cen_d    = 1'b0;
    shift_d  = 1'b0;
    set_d    = set_q;
    ovf_d    = ovf_q || ovf_hit;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd[0];
          sreg_d   = {1'b0, fifo_rd[WORD_W-1:1]};
          wbits_d  = 6'd1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          cen_d    = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bitcnt_q == CNT_W'(BITS_PER_COL)) begin
          state_d = DONE;
          set_d   = 1'b1;
        end else if (wbits_q == 6'd32) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd[0];
            sreg_d   = {1'b0, fifo_rd[WORD_W-1:1]};
            wbits_d  = 6'd1;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            cen_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shift_d  = sreg_q[0];
          sreg_d   = {1'b0, sreg_q[WORD_W-1:1]};
          wbits_d  = wbits_q + 6'd1;
          bitcnt_d = bitcnt_q + CNT_W'(1);
          cen_d    = 1'b1;
        end
      end
      DONE: begin
        set_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      wbits_d  = '0;
      set_d    = 1'b0;
      ovf_d    = 1'b0;
      cen_d    = 1'b0;
      shift_d  = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  // All loader state and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      wbits_q  <= '0;
      bitcnt_q <= '0;
      cen_q    <= 1'b0;
      shift_q  <= 1'b0;
      set_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      wbits_q  <= wbits_d;
      bitcnt_q <= bitcnt_d;
      cen_q    <= cen_d;
      shift_q  <= shift_d;
      set_q    <= set_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign shift_out = shift_q;
  assign cen       = cen_q;
  assign set_out   = set_q;

endmodule

// File: tb/tb_wb_cfg_loader.sv
// Directed bench for wb_cfg_loader: a bit-stream scoreboard built from the
// words written, plus literal expectations for registers and timing.
module tb_wb_cfg_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          BITS = 136;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack, sh, cen, set_o;
  logic [31:0] dat_r;

  wb_cfg_loader #(
    .BASE_ADDR    (BASE),
    .BITS_PER_COL (BITS),
    .FIFO_DEPTH   (2)
  ) u_dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .shift_out (sh),
    .cen       (cen),
    .set_out   (set_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Stream model: expected bits in order, bits seen, completion and overflow.
  bit exp_q[$];
  int nbits    = 0;
  bit done_m   = 0;
  bit ovf_m    = 0;
  int run_len  = 0;
  int last_run = 0;
  bit seen [0:BITS-1];

  function automatic void model_clear();
    exp_q.delete();
    nbits    = 0;
    done_m   = 0;
    ovf_m    = 0;
    run_len  = 0;
    last_run = 0;
  endfunction

  // Every cycle: set_out must track completion; each cen bit must be the next expected bit.
  always @(negedge clk) begin
    bit e;
    chk("set_out", set_o, done_m);
    if (cen === 1'b1) begin
      run_len++;
      if (done_m || exp_q.size() == 0) begin
        chk("cen_unexpected", cen, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("shift_out", sh, e);
        if (nbits < BITS) seen[nbits] = sh;
        nbits++;
        if (nbits == BITS) done_m = 1;
      end
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rdata, output bit acked);
    acked = 0;
    rdata = '0;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    if (w && a == BASE + 32'd4 && d[0]) model_clear();
    for (int i = 0; i < 100 && !acked; i++) begin
      tick();
      if (ack === 1'b1) begin
        acked = 1;
        rdata = dat_r;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (acked && w && a == BASE && s == 4'hF) begin
      if (done_m) ovf_m = 1;
      else for (int b = 0; b < 32; b++) exp_q.push_back(d[b]);
    end
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    bit          ok;
    xfer(a, 1'b1, d, s, r, ok);
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] exp);
    logic [31:0] r;
    bit          ok;
    xfer(a, 1'b0, 32'h0, s, r, ok);
    chk({name, "_ack"}, 32'(ok), 32'd1);
    chk(name, r, exp);
  endtask

  bit first_seq [24] = '{1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0,0,1,0,1};

  initial begin
    int hits;
    int i;
    ticks(3);
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", dat_r, 32'h0);
    chk("rst_shift", sh, 1'b0);
    chk("rst_cen", cen, 1'b0);
    chk("rst_set", set_o, 1'b0);
    rst = 1'b0;
    tick();
    rd("rst_bitcnt", BASE + 32'hC, 4'hF, 32'd0);
    rd("rst_status", BASE + 32'h8, 4'hF, 32'h0);

    // Two-word load: 64 contiguous bits, column not yet complete.
    wr("w1_ack", BASE, 32'hA5A5_0001, 4'hF);
    chk("first_bit_pre", cen, 1'b0);
    wr("w2_ack", BASE, 32'h8000_0000, 4'hF);
    chk("bits_after_w2", nbits, 32'd2);
    ticks(70);
    chk("load_run_len", last_run, 32'd64);
    chk("load_nbits", nbits, 32'd64);
    for (int k = 0; k < 24; k++) chk("load_seq", 32'(seen[k]), 32'(first_seq[k]));
    chk("load_bit33", 32'(seen[32]), 32'd0);
    chk("load_bit64", 32'(seen[63]), 32'd1);
    rd("load_bitcnt", BASE + 32'hC, 4'hF, 32'd64);
    rd("load_status", BASE + 32'h8, 4'hF, 32'h0);
    wr("clr1_ack", BASE + 32'h4, 32'h1, 4'hF);
    ticks(2);
    rd("clr1_bitcnt", BASE + 32'hC, 4'hF, 32'd0);

    // Back-to-back writes into a 2-deep FIFO: the 4th stalls until a pop.
    ticks(2);
    wr("bp1_ack", BASE, 32'h1234_5678, 4'hF);
    wr("bp2_ack", BASE, 32'hDEAD_BEEF, 4'hF);
    wr("bp3_ack", BASE, 32'h0F0F_00FF, 4'hF);
    wr("bp4_ack", BASE, 32'hCAFE_0001, 4'hF);
    chk("bp_stall_release", nbits, 32'd34);
    ticks(110);
    chk("bp_run_len", last_run, 32'd128);
    chk("bp_nbits", nbits, 32'd128);
    rd("bp_bitcnt", BASE + 32'hC, 4'hF, 32'd128);

    // Partial last word: only 8 of 32 bits complete the column.
    wr("part_ack", BASE, 32'h0000_00F3, 4'hF);
    ticks(15);
    chk("part_run_len", last_run, 32'd8);
    chk("part_set", set_o, 1'b1);
    rd("part_status", BASE + 32'h8, 4'hF, 32'h1);
    rd("part_bitcnt", BASE + 32'hC, 4'hF, 32'd136);

    // Write after completion: acked, dropped, sticky overflow.
    wr("ovf_ack", BASE, 32'hFFFF_FFFF, 4'hF);
    ticks(5);
    chk("ovf_model", 32'(ovf_m), 32'd1);
    rd("ovf_status", BASE + 32'h8, 4'hF, 32'h5);
    ticks(1);
    wr("clr2_ack", BASE + 32'h4, 32'h1, 4'hF);
    chk("clr2_set", set_o, 1'b0);
    rd("clr2_status", BASE + 32'h8, 4'hF, 32'h0);
    rd("clr2_bitcnt", BASE + 32'hC, 4'hF, 32'd0);

    // Reset at bit 10 of a word, then a full reload.
    ticks(2);
    wr("rs_ack", BASE, 32'h1357_9BDF, 4'hF);
    i = 0;
    while (nbits != 10 && i < 60) begin
      tick();
      i++;
    end
    chk("rs_reach_bit10", nbits, 32'd10);
    rst = 1'b1;
    model_clear();
    tick();
    chk("rs_cen", cen, 1'b0);
    chk("rs_set", set_o, 1'b0);
    chk("rs_shift", sh, 1'b0);
    chk("rs_ack", ack, 1'b0);
    chk("rs_dat", dat_r, 32'h0);
    rst = 1'b0;
    tick();
    rd("rs_bitcnt", BASE + 32'hC, 4'hF, 32'd0);
    ticks(1);
    wr("rl1_ack", BASE, 32'h0000_FFFF, 4'hF);
    wr("rl2_ack", BASE, 32'h8421_8421, 4'hF);
    wr("rl3_ack", BASE, 32'h0000_0000, 4'hF);
    wr("rl4_ack", BASE, 32'hFFFF_0000, 4'hF);
    wr("rl5_ack", BASE, 32'h0000_005A, 4'hF);
    ticks(100);
    chk("rl_set", set_o, 1'b1);
    chk("rl_nbits", nbits, 32'd136);
    rd("rl_bitcnt", BASE + 32'hC, 4'hF, 32'd136);

    // Address decode: out-of-window gets no ack; narrow-sel STATUS read is acked.
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; dat_w = 32'h1; sel = 4'hF;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack !== 1'b0) hits++;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("oob_noack", hits, 32'd0);
    ticks(1);
    rd("sel1_status", BASE + 32'h8, 4'h1, 32'h1);
    rd("ctrl_read_zero", BASE + 32'h4, 4'hF, 32'h0);
    wr("ro_write_ack", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    ticks(1);
    wr("clr3_ack", BASE + 32'h4, 32'h1, 4'hF);
    ticks(1);
    wr("sel3_ack", BASE, 32'hFFFF_FFFF, 4'h3);
    ticks(5);
    rd("sel3_status", BASE + 32'h8, 4'hF, 32'h0);
    rd("sel3_bitcnt", BASE + 32'hC, 4'hF, 32'd0);

    ticks(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
